seq101_chan_sched: RTL and testbench



---
 rtl/seq101_pkg.sv | 18 +
 rtl/seq101_chan_sched_if.sv | 38 +++
 rtl/seq101_next.sv | 35 +++
 rtl/seq101_chan_sched.sv | 129 ++++++++++++
 tb/tb_seq101_chan_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seq101_pkg.sv
// -----------------------------------------------------------------------------
// seq101_pkg
// Shared types for the time-multiplexed "101" sequence detector.
//   DEF_N_CH     default number of serial channels
//   seq_state_e  2-bit per-channel detector state (A=00, B=01, C=10, D=11)
// -----------------------------------------------------------------------------
package seq101_pkg;

    localparam int DEF_N_CH = 4;

    typedef enum logic [1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_C = 2'b10,
        S_D = 2'b11
    } seq_state_e;

endpackage

// File: rtl/seq101_chan_sched_if.sv
// -----------------------------------------------------------------------------
// seq101_chan_sched_if
// Channel handshake, match report and hit-counter read bus.
//   ch_valid/ch_bit/ch_clr  per-channel request, serial bit, state clear
//   ch_ready                one-hot grant back to the front-ends
//   match_valid/match_ch    registered match pulse and channel id
//   cnt_sel/cnt_data        hit-counter read port
// Modports: master = front-end/consumer side, slave = scheduler.
// -----------------------------------------------------------------------------
interface seq101_chan_sched_if
    import seq101_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = 8
) ();

    localparam int CW = $clog2(N_CH);

    logic [N_CH-1:0]  ch_valid;
    logic [N_CH-1:0]  ch_bit;
    logic [N_CH-1:0]  ch_ready;
    logic [N_CH-1:0]  ch_clr;
    logic             match_valid;
    logic [CW-1:0]    match_ch;
    logic [CW-1:0]    cnt_sel;
    logic [CNT_W-1:0] cnt_data;

    modport master (
        output ch_valid, ch_bit, ch_clr, cnt_sel,
        input  ch_ready, match_valid, match_ch, cnt_data
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clr, cnt_sel,
        output ch_ready, match_valid, match_ch, cnt_data
    );

endinterface

// File: rtl/seq101_next.sv
// -----------------------------------------------------------------------------
// seq101_next
// Pure next-state function of the overlapping "101" Moore detector.
//   state_i  current state       w_i     input bit
//   state_o  next state          is_d_o  next state is D (sequence seen)
//
// state | meaning
// ------+----------------
// S_A   | idle
// S_B   | got "1"
// S_C   | got "10"
// S_D   | got "101"
// -----------------------------------------------------------------------------
module seq101_next
    import seq101_pkg::*;
(
    input  seq_state_e state_i,
    input  logic       w_i,
    output seq_state_e state_o,
    output logic       is_d_o
);

    always_comb begin
        state_o = S_A;
        case (state_i)
            S_A:     state_o = w_i ? S_B : S_A;
            S_B:     state_o = w_i ? S_B : S_C;
            S_C:     state_o = w_i ? S_D : S_A;
            S_D:     state_o = w_i ? S_B : S_C;
            default: state_o = S_A;
        endcase
        is_d_o = (state_o == S_D);
    end

endmodule

// File: rtl/seq101_chan_sched.sv
// -----------------------------------------------------------------------------
// seq101_chan_sched
// One "101" detector shared by N_CH serial channels. A round-robin arbiter
// grants one requesting channel per cycle; its bit advances that channel's
// stored state through the shared seq101_next function.
//   clk    clock, rising edge
//   Reset  asynchronous, active-low reset
//   bus    seq101_chan_sched_if.slave (grant, match report, counter read)
// Optional: define SEQ_HIT_CNT_EN for per-channel saturating hit counters;
// otherwise cnt_data reads 0.
// -----------------------------------------------------------------------------
module seq101_chan_sched
    import seq101_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                Reset,
    seq101_chan_sched_if.slave bus
);

    localparam int CW = $clog2(N_CH);

    seq_state_e    state_q [N_CH];
    seq_state_e    state_d [N_CH];
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic          match_valid_q, match_valid_d;
    logic [CW-1:0] match_ch_q, match_ch_d;

    logic            gnt_any;
    logic [CW-1:0]   gnt_idx;
    logic [N_CH-1:0] gnt_vec;
    seq_state_e      cur_st, nxt_st;
    logic            nxt_is_d;

    // Scan starts at rr_ptr and wraps; first requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_any && bus.ch_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    assign bus.ch_ready = gnt_vec;
    assign cur_st       = state_q[gnt_idx];

    seq101_next u_next (
        .state_i (cur_st),
        .w_i     (bus.ch_bit[gnt_idx]),
        .state_o (nxt_st),
        .is_d_o  (nxt_is_d)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) rr_ptr_d = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            if (bus.ch_clr[i])
                state_d[i] = S_A;
            else if (gnt_any && (gnt_idx == CW'(i)))
                state_d[i] = nxt_st;
        end

        // A clear on the granted channel swallows the match.
        match_valid_d = gnt_any && nxt_is_d && !bus.ch_clr[gnt_idx];
        match_ch_d    = match_valid_d ? gnt_idx : match_ch_q;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= S_A;
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
            rr_ptr_q      <= rr_ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_ch    = match_ch_q;

`ifdef SEQ_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.ch_clr[i])
                cnt_d[i] = '0;
            else if (match_valid_d && (gnt_idx == CW'(i)) && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Selects beyond the last channel (non power-of-two N_CH) read as 0.
    assign bus.cnt_data = (int'(bus.cnt_sel) < N_CH) ? cnt_q[bus.cnt_sel] : '0;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^bus.cnt_sel;
    assign bus.cnt_data   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq101_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_seq101_chan_sched
// Directed bench for seq101_chan_sched with N_CH=4, CNT_W=8. Expected grants,
// match pulses and counter values are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_seq101_chan_sched;

    logic clk;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    seq101_chan_sched_if #(.N_CH(4), .CNT_W(8)) bus ();

    seq101_chan_sched #(.N_CH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive, check grant, clock, check registered outputs.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] exp_rdy,
                       input logic exp_mv, input logic [1:0] exp_mch);
        bus.ch_valid = v;
        bus.ch_bit   = b;
        bus.ch_clr   = c;
        #1;
        chk({tag, ".rdy"}, 32'(bus.ch_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".mv"},  32'(bus.match_valid), 32'(exp_mv));
        chk({tag, ".mch"}, 32'(bus.match_ch), 32'(exp_mch));
    endtask

    task automatic feed(input logic bitv, output logic mv);
        bus.ch_valid = 4'b0001;
        bus.ch_bit   = {3'b000, bitv};
        bus.ch_clr   = 4'b0000;
        @(posedge clk);
        #1;
        mv = bus.match_valid;
    endtask

    task automatic idle_in();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = '0;
    endtask

`ifdef SEQ_HIT_CNT_EN
    task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.cnt_sel = sel;
        #1;
        chk(tag, 32'(bus.cnt_data), 32'(exp));
    endtask
`endif

    initial begin
        logic mv;
        int   pulses;

        idle_in();
        bus.cnt_sel = '0;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1;
        chk("rst.mv",  32'(bus.match_valid), 32'd0);
        chk("rst.mch", 32'(bus.match_ch), 32'd0);
        chk("rst.rdy", 32'(bus.ch_ready), 32'd0);
        @(posedge clk);
        #1 Reset = 1'b1;

        // ch0 alone: 1,0,1
        cyc("t1a", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd0);
        cyc("t1b", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0);
        cyc("t1c", 4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0);
        cyc("t1d", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);

        // move rr_ptr to 0, then full contention rotates 0,1,2,3,0,...
        cyc("t2p", 4'h8, 4'h0, 4'h0, 4'h8, 1'b0, 2'd0);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("t2_%0d", k), 4'hF, 4'h0, 4'h0, 4'(1 << (k % 4)), 1'b0, 2'd0);

        // ch1 sends 1,0,1 and ch2 sends 1,1,0 under contention, then ch2 sends 1
        cyc("t3a", 4'h6, 4'h6, 4'h0, 4'h2, 1'b0, 2'd0);
        cyc("t3b", 4'h6, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
        cyc("t3c", 4'h6, 4'h4, 4'h0, 4'h2, 1'b0, 2'd0);
        cyc("t3d", 4'h6, 4'h6, 4'h0, 4'h4, 1'b0, 2'd0);
        cyc("t3e", 4'h6, 4'h2, 4'h0, 4'h2, 1'b1, 2'd1);
        cyc("t3f", 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 2'd1);
        cyc("t3g", 4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2);

        // ch3 overlapping 1,0,1,0,1; bits on non-granted lanes are noise
        cyc("t4a", 4'h8, 4'hD, 4'h0, 4'h8, 1'b0, 2'd2);
        cyc("t4b", 4'h8, 4'h5, 4'h0, 4'h8, 1'b0, 2'd2);
        cyc("t4c", 4'h8, 4'hD, 4'h0, 4'h8, 1'b1, 2'd3);
        cyc("t4d", 4'h8, 4'h5, 4'h0, 4'h8, 1'b0, 2'd3);
        cyc("t4e", 4'h8, 4'hD, 4'h0, 4'h8, 1'b1, 2'd3);
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t4.cnt0", 2'd0, 8'd1);
        chk_cnt("t4.cnt1", 2'd1, 8'd1);
        chk_cnt("t4.cnt2", 2'd2, 8'd1);
        chk_cnt("t4.cnt3", 2'd3, 8'd2);
`endif

        // clear on a granted bit, then clear on an idle channel
        cyc("t5a", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd3);
        cyc("t5b", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd3);
        cyc("t5c", 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 2'd3);
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t5.cnt0", 2'd0, 8'd0);
        chk_cnt("t5.cnt1", 2'd1, 8'd1);
`endif
        cyc("t5d", 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd3);
        cyc("t5e", 4'h1, 4'h1, 4'h0, 4'h1, 1'b0, 2'd3);
        cyc("t5f", 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 2'd3);
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t5.cnt1c", 2'd1, 8'd0);
`endif
        cyc("t5g", 4'h2, 4'h0, 4'h0, 4'h2, 1'b0, 2'd3);
        cyc("t5h", 4'h2, 4'h2, 4'h0, 4'h2, 1'b0, 2'd3);

        // ch2 match, then reset while the pulse is high
        cyc("t6a", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd3);
        cyc("t6b", 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 2'd3);
        cyc("t6c", 4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2);
        idle_in();
        Reset = 1'b0;
        #1;
        chk("t6.rst.mv",  32'(bus.match_valid), 32'd0);
        chk("t6.rst.mch", 32'(bus.match_ch), 32'd0);
        chk("t6.rst.rdy", 32'(bus.ch_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t6.rst.mv2", 32'(bus.match_valid), 32'd0);
        Reset = 1'b1;
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t6.cnt2", 2'd2, 8'd0);
        chk_cnt("t6.cnt3", 2'd3, 8'd0);
`endif

        // ch2 sends 1,0, reset discards it, then a 1 must not match
        cyc("t7a", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);
        cyc("t7b", 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 2'd0);
        idle_in();
        Reset = 1'b0;
        #1;
        chk("t7.rst.mv", 32'(bus.match_valid), 32'd0);
        @(posedge clk);
        #1 Reset = 1'b1;
        cyc("t7c", 4'hF, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0);
        cyc("t7d", 4'h4, 4'h4, 4'h0, 4'h4, 1'b0, 2'd0);

        // ch0 stream 1,(0,1)x255 -> 255 matches; one more 0,1 -> 256
        pulses = 0;
        feed(1'b1, mv);
        pulses += int'(mv);
        for (int i = 0; i < 255; i++) begin
            feed(1'b0, mv);
            pulses += int'(mv);
            feed(1'b1, mv);
            pulses += int'(mv);
        end
        chk("t8.pulses255", 32'(pulses), 32'd255);
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t8.cnt255", 2'd0, 8'd255);
`endif
        feed(1'b0, mv);
        pulses += int'(mv);
        feed(1'b1, mv);
        pulses += int'(mv);
        chk("t8.pulses256", 32'(pulses), 32'd256);
        chk("t8.mch", 32'(bus.match_ch), 32'd0);
`ifdef SEQ_HIT_CNT_EN
        chk_cnt("t8.cntsat", 2'd0, 8'd255);
`else
        bus.cnt_sel = 2'd3;
        #1;
        chk("t8.cnt_off", 32'(bus.cnt_data), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
